// File: rtl/byte_serializer_if.sv
// Handshake bundle for byte_serializer: word-in stream and byte-out stream.
// master drives words in and accepts bytes; slave is the serializer itself.
interface byte_serializer_if #(
  parameter int DATA_BYTES = 69,
  parameter int LEN_W      = $clog2(DATA_BYTES + 1)
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_BYTES*8-1:0] in_data;
  logic [LEN_W-1:0]        in_len;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [7:0]              out_byte;
  logic                    out_start;
  logic                    out_last;

  modport master (
    output in_valid, in_data, in_len, in_last, out_ready,
    input  in_ready, out_valid, out_byte, out_start, out_last
  );

  modport slave (
    input  in_valid, in_data, in_len, in_last, out_ready,
    output in_ready, out_valid, out_byte, out_start, out_last
  );
endinterface

// File: rtl/byte_serializer.sv
// Wide-word to byte-stream serializer, lanes emitted LSB-first at 1 byte/clk.
// Optional BYTE_SERIALIZER_BYTECNT_EN adds a per-frame 32-bit byte_count output.
module byte_serializer #(
  parameter int DATA_BYTES = 69,
  parameter int LEN_W      = $clog2(DATA_BYTES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  byte_serializer_if.slave    bus,
  output logic                busy
`ifdef BYTE_SERIALIZER_BYTECNT_EN
  ,
  output logic [31:0]         byte_count
`endif
);
  localparam int               DW      = DATA_BYTES * 8;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_BYTES);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    data_q, data_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             last_q, last_d;
  logic             start_q, start_d;
  logic [LEN_W-1:0] len_clamped;
  logic             in_xfer, out_xfer;

  assign bus.out_valid = (state_q == SHIFT);
  assign busy          = (state_q == SHIFT);
  assign bus.out_byte  = data_q[7:0];
  assign bus.out_start = bus.out_valid && start_q;
  assign bus.out_last  = bus.out_valid && last_q && (rem_q == ONE);
  // Refill on the final byte's transfer edge so consecutive words leave no gap.
  assign bus.in_ready  = !rst && ((state_q == IDLE) || ((rem_q == ONE) && bus.out_ready));

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    rem_d       = rem_q;
    last_d      = last_q;
    start_d     = start_q;
    len_clamped = (bus.in_len > MAX_LEN) ? MAX_LEN : bus.in_len;
    in_xfer     = bus.in_valid && bus.in_ready;
    out_xfer    = bus.out_valid && bus.out_ready;

    if (out_xfer) begin
      data_d  = data_q >> 8;
      rem_d   = rem_q - ONE;
      start_d = bus.out_last;
      if (rem_q == ONE) state_d = IDLE;
    end

    // A zero-length word is consumed here but leaves every register untouched.
    if (in_xfer && (len_clamped != '0)) begin
      data_d  = bus.in_data;
      rem_d   = len_clamped;
      last_d  = bus.in_last;
      state_d = SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      start_q <= start_d;
    end
  end

`ifdef BYTE_SERIALIZER_BYTECNT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        clr_q, clr_d;

  // The final count stays visible for one cycle after out_last, then clears.
  always_comb begin
    cnt_d = (clr_q ? '0 : cnt_q) + 32'(out_xfer);
    clr_d = out_xfer && bus.out_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      clr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clr_q <= clr_d;
    end
  end

  assign byte_count = cnt_q;
`endif
endmodule

// File: tb/tb_byte_serializer.sv
// Directed self-checking bench for byte_serializer with DATA_BYTES=4.
// Define BYTE_SERIALIZER_BYTECNT_EN to also exercise byte_count.
module tb_byte_serializer;
  localparam int DB = 4;
  localparam int LW = $clog2(DB + 1);

  localparam logic [7:0] E35 [6] = '{8'h0A, 8'h0B, 8'h0B, 8'h0B, 8'h0C, 8'h0D};
  localparam logic [5:0] R35 = 6'b111001;
  localparam logic [5:0] S35 = 6'b000001;
  localparam logic [5:0] L35 = 6'b100000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
`ifdef BYTE_SERIALIZER_BYTECNT_EN
  logic [31:0] byte_count;
`endif
  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  byte_serializer_if #(.DATA_BYTES(DB), .LEN_W(LW)) bus ();

  byte_serializer #(.DATA_BYTES(DB), .LEN_W(LW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
`ifdef BYTE_SERIALIZER_BYTECNT_EN
    ,
    .byte_count (byte_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] data, input logic [LW-1:0] len, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_len   = len;
    bus.in_last  = last;
  endtask

  task automatic drop();
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] b, input logic s, input logic l);
    #1;
    check_eq({tag, "_valid"}, bus.out_valid, 1);
    check_eq({tag, "_byte"},  bus.out_byte,  b);
    check_eq({tag, "_start"}, bus.out_start, s);
    check_eq({tag, "_last"},  bus.out_last,  l);
    check_eq({tag, "_busy"},  busy,          1);
  endtask

  task automatic expect_idle(input string tag);
    #1;
    check_eq({tag, "_valid"},    bus.out_valid, 0);
    check_eq({tag, "_busy"},     busy,          0);
    check_eq({tag, "_in_ready"}, bus.in_ready,  1);
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_len    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset behaviour
    #1;
    check_eq("rst_in_ready", bus.in_ready, 0);
    tick();
    tick();
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_busy",      busy,          0);
    check_eq("rst_out_byte",  bus.out_byte,  8'h00);
    check_eq("rst_out_start", bus.out_start, 0);
    check_eq("rst_out_last",  bus.out_last,  0);
    check_eq("rst_in_ready_held", bus.in_ready, 0);
    rst = 1'b0;
    #1;
    check_eq("rel_in_ready", bus.in_ready, 1);

    // Single full word, LSB-first
    offer(32'hDDCCBBAA, 4, 1'b1);
    tick();
    drop();
    expect_byte("w1_b0", 8'hAA, 1, 0); tick();
    expect_byte("w1_b1", 8'hBB, 0, 0); tick();
    expect_byte("w1_b2", 8'hCC, 0, 0); tick();
    expect_byte("w1_b3", 8'hDD, 0, 1); tick();
    expect_idle("w1_end");

    // Back-to-back words, len 3 then 2
    offer(32'h00332211, 3, 1'b0);
    #1;
    check_eq("b2b_accept_a", bus.in_ready, 1);
    tick();
    offer(32'h00005544, 2, 1'b1);
    expect_byte("b2b_0", 8'h11, 1, 0);
    check_eq("b2b_0_in_ready", bus.in_ready, 0);
    tick();
    expect_byte("b2b_1", 8'h22, 0, 0);
    check_eq("b2b_1_in_ready", bus.in_ready, 0);
    tick();
    expect_byte("b2b_2", 8'h33, 0, 0);
    check_eq("b2b_2_in_ready", bus.in_ready, 1);
    tick();
    drop();
    expect_byte("b2b_3", 8'h44, 0, 0); tick();
    expect_byte("b2b_4", 8'h55, 0, 1); tick();
    expect_idle("b2b_end");

    // Downstream stalls 1,0,0,1
    offer(32'h0D0C0B0A, 4, 1'b1);
    tick();
    drop();
    for (int i = 0; i < 6; i++) begin
      bus.out_ready = R35[i];
      expect_byte($sformatf("stall_%0d", i), E35[i], S35[i], L35[i]);
      tick();
    end
    bus.out_ready = 1'b1;
    expect_idle("stall_end");

    // Zero-length word, then over-long word clamped to 4
    offer(32'hFFFFFFFF, 0, 1'b1);
    #1;
    check_eq("len0_accept", bus.in_ready, 1);
    tick();
    drop();
    expect_idle("len0_after");
    offer(32'h78563412, 7, 1'b1);
    tick();
    drop();
    expect_byte("clamp_0", 8'h12, 1, 0); tick();
    expect_byte("clamp_1", 8'h34, 0, 0); tick();
    expect_byte("clamp_2", 8'h56, 0, 0); tick();
    expect_byte("clamp_3", 8'h78, 0, 1); tick();
    expect_idle("clamp_end");

    // Reset mid-word
    offer(32'hA4A3A2A1, 4, 1'b1);
    tick();
    drop();
    expect_byte("mid_0", 8'hA1, 1, 0); tick();
    expect_byte("mid_1", 8'hA2, 0, 0); tick();
    rst = 1'b1;
    #1;
    check_eq("mid_rst_in_ready", bus.in_ready, 0);
    tick();
    rst = 1'b0;
    expect_idle("mid_after_rst");
    tick();
    expect_idle("mid_after_rst2");
    offer(32'h0000C2C1, 2, 1'b0);
    tick();
    drop();
    expect_byte("rearm_0", 8'hC1, 1, 0); tick();
    expect_byte("rearm_1", 8'hC2, 0, 0); tick();
    expect_idle("rearm_gap");
    offer(32'h000000D1, 1, 1'b1);
    tick();
    drop();
    expect_byte("cont_0", 8'hD1, 0, 1); tick();
    expect_idle("cont_end");

`ifdef BYTE_SERIALIZER_BYTECNT_EN
    // Six-byte frame over two words
    tick();
    check_eq("cnt_init", byte_count, 0);
    offer(32'h04030201, 4, 1'b0);
    tick();
    offer(32'h00000605, 2, 1'b1);
    for (int k = 0; k < 6; k++) begin
      #1;
      check_eq($sformatf("cnt_%0d", k),  byte_count,   k);
      check_eq($sformatf("cntb_%0d", k), bus.out_byte, k + 1);
      tick();
      if (k == 3) drop();
    end
    #1;
    check_eq("cnt_full", byte_count, 6);
    check_eq("cnt_full_valid", bus.out_valid, 0);
    tick();
    check_eq("cnt_clear", byte_count, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule

// File: doc/byte_serializer.md
BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 69, the number of byte lanes in in_data (69 gives 552 bits).
REQ-002 SHALL have parameter LEN_W, default $clog2(DATA_BYTES+1), the width of in_len.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  an upstream word is offered.
REQ-006 SHALL have port in_ready  output  1  the block accepts the word on this edge.
REQ-007 SHALL have port in_data  input  DATA_BYTES*8  the word; lane k is in_data[8k+7:8k].
REQ-008 SHALL have port in_len  input  LEN_W  the count of valid lanes, starting at lane 0.
REQ-009 SHALL have port in_last  input  1  this word ends the frame.
REQ-010 SHALL have port out_valid  output  1  out_byte is valid.
REQ-011 SHALL have port out_ready  input  1  the downstream consumer (PNG decoder ibyte path) accepts the byte.
REQ-012 SHALL have port out_byte  output  8  the serialized byte.
REQ-013 SHALL have port out_start  output  1  out_byte is the first byte of a frame.
REQ-014 SHALL have port out_last  output  1  out_byte is the final byte of a frame.
REQ-015 SHALL have port busy  output  1  the block holds unsent bytes.

Function
REQ-016 SHALL implement two states, IDLE and SHIFT; in IDLE, in_ready=1 and out_valid=0.
REQ-017 An input transfer SHALL occur on an edge where in_valid&&in_ready are both 1; the block SHALL latch in_data, clamp in_len to min(in_len, DATA_BYTES), latch in_last, and go to SHIFT.
REQ-018 out_valid SHALL rise on the cycle after the input transfer, presenting lane 0; latency is 1 clock.
REQ-019 Lanes SHALL be emitted LSB-first (0, 1, …, len-1), one per output transfer (out_valid&&out_ready); throughput is 1 byte/clk.
REQ-020 While out_valid=1 and out_ready=0, out_byte, out_start and out_last SHALL hold stable; out_valid SHALL NOT drop without a transfer.
REQ-021 The remaining-byte counter SHALL be LEN_W bits, decrement on each output transfer, and never underflow.
REQ-022 In SHIFT, in_ready SHALL be 1 only when remaining==1 and out_ready=1, so back-to-back words incur zero bubble cycles.
REQ-023 If the last byte transfers with no new word accepted, the block SHALL return to IDLE on that edge.
REQ-024 A word with in_len=0 SHALL be accepted and discarded with no output; its in_last SHALL be ignored; the state stays or returns to IDLE.
REQ-025 out_last SHALL be 1 only on lane len-1 of a word latched with in_last=1.
REQ-026 out_start SHALL be 1 on the first emitted byte after reset or after an out_last transfer, and 0 otherwise.
REQ-027 busy SHALL equal (state==SHIFT).

Reset
REQ-028 When rst=1 at an edge, the block SHALL go to IDLE, clear remaining, set out_valid, out_start, out_last and busy to 0, set out_byte to 8'h00, and arm the start flag.
REQ-029 in_ready SHALL be 0 while rst=1 and 1 on the first cycle after rst falls.
REQ-030 Reset asserted mid-word SHALL discard all unsent bytes; no byte SHALL be emitted after release until a new transfer.

Configuration
REQ-031 With BYTE_SERIALIZER_BYTECNT_EN defined, the block SHALL add output byte_count (32 bits): 0 at reset, +1 per output transfer, cleared to 0 on the edge following an out_last transfer, wrapping at 2^32.
REQ-032 Without BYTE_SERIALIZER_BYTECNT_EN, the byte_count port and its counter SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-033 DATA_BYTES=4, word 32'hDDCCBBAA, len=4, last=1, out_ready=1 -> bytes AA, BB, CC, DD on 4 consecutive cycles starting 1 cycle after accept; out_start on AA, out_last on DD.
REQ-034 Two words back-to-back (len 3 then 2) with out_ready=1 -> 5 bytes on 5 consecutive cycles, second accept on the edge the 3rd byte transfers, no bubble.
REQ-035 out_ready toggled 1,0,0,1 during a word -> each byte held stable while stalled, no byte lost or duplicated.
REQ-036 in_len=0 word, then in_len=7 on DATA_BYTES=4 -> first word produces nothing; second emits exactly 4 bytes.
REQ-037 rst pulsed after 2 of 4 bytes -> out_valid=0 the next cycle; next word's first byte carries out_start=1.
REQ-038 With BYTE_SERIALIZER_BYTECNT_EN, frame of 6 bytes -> byte_count reaches 6, then reads 0 after the out_last transfer.
